// File: rtl/special_reg_file.sv
// Accumulator-datapath register file: hardwired Zero/One entries, a flags register
// with a carry-out merge port, and a dedicated accumulator write-back path.
module special_reg_file #(
  parameter  int W        = 8,
  parameter  int NREGS    = 16,
  parameter  int NRD      = 2,
  parameter  int ACC_IDX  = 15,
  parameter  int BCMP_IDX = 14,
  parameter  int BTGT_IDX = 13,
  parameter  int BITS_IDX = 12,
  parameter  int ONE_IDX  = 11,
  parameter  int ZERO_IDX = 10,
  parameter  int FWD      = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              acc_we,
  input  logic [W-1:0]      acc_wdata,
  input  logic              flag_we,
  input  logic              carry_out,
  output logic [W-1:0]      acc,
  output logic              carry_in,
  output logic              branch_dir
);

  // Branch-comparison and branch-target registers are plain storage; only their range is checked.
  if (W < 2 || NRD < 1 || NRD > 4 || (1 << AW) != NREGS ||
      BCMP_IDX >= NREGS || BTGT_IDX >= NREGS || ACC_IDX >= NREGS) begin : g_bad_cfg
    $fatal(1, "special_reg_file: illegal parameter set");
  end

  logic [W-1:0]     w_q    [NREGS];
  logic [W-1:0]     w_next [NREGS];
  logic [NREGS-1:0] w_we;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == ZERO_IDX || i == ONE_IDX) begin : g_const
      assign w_q[i]    = (i == ONE_IDX) ? W'(1) : '0;
      assign w_next[i] = w_q[i];
      assign w_we[i]   = 1'b0;
    end else begin : g_store
      logic         w_hit;
      logic         w_upd;
      logic [W-1:0] w_d;
      logic [W-1:0] r_q;

      assign w_hit = wr_en && (wr_addr == AW'(i));

      // General write port wins over the accumulator path; carry_out always owns Bits[0].
      always_comb begin
        w_upd = w_hit;
        w_d   = wr_data;
        if (i == ACC_IDX) begin
          if (!w_hit && acc_we) begin
            w_upd = 1'b1;
            w_d   = acc_wdata;
          end
        end else if (i == BITS_IDX) begin
          if (flag_we) begin
            w_upd = 1'b1;
            w_d   = {(w_hit ? wr_data[W-1:1] : r_q[W-1:1]), carry_out};
          end
        end
      end

      // NOTE: every storage word is reset, so reads after reset are defined rather than X.
      always_ff @(posedge CLK or posedge reset) begin
        if (reset)      r_q <= '0;
        else if (w_upd) r_q <= w_d;
      end

      assign w_q[i]    = r_q;
      assign w_next[i] = w_d;
      assign w_we[i]   = w_upd && !reset;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (FWD != 0 && w_we[rd_addr[k*AW +: AW]])
        rd_data[k*W +: W] = w_next[rd_addr[k*AW +: AW]];
      else
        rd_data[k*W +: W] = w_q[rd_addr[k*AW +: AW]];
    end
  end

  assign acc      = w_q[ACC_IDX];
  assign carry_in = w_q[BITS_IDX][1];

  if (W >= 4) begin : g_bdir
    assign branch_dir = w_q[BITS_IDX][3];
  end else begin : g_no_bdir
    assign branch_dir = 1'b0;
  end

endmodule

// File: tb/tb_special_reg_file.sv
// Scoreboarded bench for special_reg_file: default (bypass), no-bypass and wide instances.
module tb_special_reg_file;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  checks = 0;
  int  errors = 0;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wr_en, acc_we, flag_we, carry_out;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data, acc_wdata;
  logic [7:0]  acc_a, acc_b;
  logic        ci_a, ci_b, bd_a, bd_b;

  logic [14:0] w_rd_addr;
  logic [47:0] w_rd_data;
  logic        w_wr_en, w_acc_we, w_flag_we, w_carry_out;
  logic [4:0]  w_wr_addr;
  logic [15:0] w_wr_data, w_acc_wdata, w_acc;
  logic        w_ci, w_bd;

  always #5 CLK = ~CLK;

  special_reg_file u_dut_a (
    .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .acc_we(acc_we), .acc_wdata(acc_wdata), .flag_we(flag_we), .carry_out(carry_out),
    .acc(acc_a), .carry_in(ci_a), .branch_dir(bd_a)
  );

  special_reg_file #(.FWD(0)) u_dut_b (
    .CLK(CLK), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .acc_we(acc_we), .acc_wdata(acc_wdata), .flag_we(flag_we), .carry_out(carry_out),
    .acc(acc_b), .carry_in(ci_b), .branch_dir(bd_b)
  );

  special_reg_file #(.W(16), .NREGS(32), .NRD(3)) u_dut_w (
    .CLK(CLK), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .acc_we(w_acc_we), .acc_wdata(w_acc_wdata), .flag_we(w_flag_we), .carry_out(w_carry_out),
    .acc(w_acc), .carry_in(w_ci), .branch_dir(w_bd)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    acc_we  = 1'b0;
    flag_we = 1'b0;
  endtask

  task automatic test_reset();
    // Load non-zero state first so the clear is observable.
    acc_we = 1'b1; acc_wdata = 8'h5A;
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'h08;
    flag_we = 1'b1; carry_out = 1'b1;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h99;
    #2 reset = 1'b1;
    sb.push_back('{"rst_acc", 16'h0000});
    sb.push_back('{"rst_carry_in", 16'h0000});
    sb.push_back('{"rst_branch_dir", 16'h0000});
    #1;
    e = sb.pop_front(); checks++;
    if ({8'h00, acc_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, acc_a, e.exp); end
    e = sb.pop_front(); checks++;
    if ({15'h0, ci_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, ci_a, e.exp); end
    e = sb.pop_front(); checks++;
    if ({15'h0, bd_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, bd_a, e.exp); end
    tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr = {4'(i), 4'(i)};
      sb.push_back('{$sformatf("rst_rd%0d_a", i), (i == 11) ? 16'h0001 : 16'h0000});
      sb.push_back('{$sformatf("rst_rd%0d_b", i), (i == 11) ? 16'h0001 : 16'h0000});
      #1;
      e = sb.pop_front(); checks++;
      if (rd_data_a[7:0] !== e.exp[7:0] || rd_data_a[15:8] !== e.exp[7:0])
        begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a, e.exp); end
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_b[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b[7:0], e.exp); end
    end
    // First write after release lands on the first rising edge with reset low.
    tick();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h42;
    rd_addr = {4'd3, 4'd3};
    #2 reset = 1'b0;
    sb.push_back('{"rst_release_write", 16'h0042});
    tick();
    idle();
    #1;
    e = sb.pop_front(); checks++;
    if ({8'h00, rd_data_b[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b[7:0], e.exp); end
  endtask

  task automatic test_constants();
    rd_addr = {4'd11, 4'd10};
    wr_en = 1'b1; wr_addr = 4'd10; wr_data = 8'hFF;
    for (int pass = 0; pass < 4; pass++) begin
      if (pass == 1) idle();
      if (pass == 2) begin wr_en = 1'b1; wr_addr = 4'd11; wr_data = 8'h55; end
      if (pass == 3) idle();
      sb.push_back('{$sformatf("const_zero_p%0d", pass), 16'h0000});
      sb.push_back('{$sformatf("const_one_p%0d", pass), 16'h0001});
      sb.push_back('{$sformatf("const_nf_p%0d", pass), 16'h0100});
      #1;
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_a[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a[7:0], e.exp); end
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_a[15:8]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a[15:8], e.exp); end
      e = sb.pop_front(); checks++;
      if (rd_data_b !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b, e.exp); end
      if (pass == 0 || pass == 2) tick();
    end
  endtask

  task automatic test_acc_contention();
    tick();
    acc_we = 1'b1; acc_wdata = 8'h3C;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'hA5;
    rd_addr = {4'd15, 4'd15};
    sb.push_back('{"acc_bypass", 16'hA5A5});
    sb.push_back('{"acc_contend", 16'h00A5});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data_a !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a, e.exp); end
    tick();
    e = sb.pop_front(); checks++;
    if ({8'h00, acc_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, acc_a, e.exp); end
    idle();
    acc_we = 1'b1; acc_wdata = 8'h3C;
    sb.push_back('{"acc_alone", 16'h003C});
    sb.push_back('{"acc_alone_nf", 16'h003C});
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if ({8'h00, acc_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, acc_a, e.exp); end
    e = sb.pop_front(); checks++;
    if ({8'h00, acc_b} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, acc_b, e.exp); end
  endtask

  task automatic test_flag_merge();
    rd_addr = {4'd12, 4'd12};
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'h0A;
    flag_we = 1'b1; carry_out = 1'b1;
    sb.push_back('{"flag_merge_bypass", 16'h000B});
    #1;
    e = sb.pop_front(); checks++;
    if ({8'h00, rd_data_a[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a[7:0], e.exp); end
    // Each step: flag_we alone with a new carry; upper bits must hold 0x0A.
    for (int step = 0; step < 3; step++) begin
      logic [7:0] bits_exp;
      bits_exp = (step == 1) ? 8'h0A : 8'h0B;
      sb.push_back('{$sformatf("flag_bits_s%0d", step), {8'h00, bits_exp}});
      sb.push_back('{$sformatf("flag_cin_s%0d", step), {15'h0, bits_exp[1]}});
      sb.push_back('{$sformatf("flag_bdir_s%0d", step), {15'h0, bits_exp[3]}});
      tick();
      idle();
      flag_we = (step < 2); carry_out = (step == 1);
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_b[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b[7:0], e.exp); end
      e = sb.pop_front(); checks++;
      if ({15'h0, ci_a} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, ci_a, e.exp); end
      e = sb.pop_front(); checks++;
      if ({15'h0, bd_b} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, bd_b, e.exp); end
    end
    idle();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h12;
    tick();
    wr_data = 8'h77;
    rd_addr = {4'd5, 4'd5};
    sb.push_back('{"byp_fwd_same", 16'h7777});
    sb.push_back('{"byp_nf_same", 16'h1212});
    sb.push_back('{"byp_fwd_next", 16'h7777});
    sb.push_back('{"byp_nf_next", 16'h7777});
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data_a !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a, e.exp); end
    e = sb.pop_front(); checks++;
    if (rd_data_b !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b, e.exp); end
    tick();
    idle();
    #1;
    e = sb.pop_front(); checks++;
    if (rd_data_a !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a, e.exp); end
    e = sb.pop_front(); checks++;
    if (rd_data_b !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b, e.exp); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'($urandom_range(0, 255));
      sb.push_back('{$sformatf("b2b_r%0d_a", i), {8'h00, wr_data}});
      sb.push_back('{$sformatf("b2b_r%0d_b", i), {8'h00, wr_data}});
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      rd_addr = {4'(i), 4'(i)};
      #1;
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_a[7:0]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_a[7:0], e.exp); end
      e = sb.pop_front(); checks++;
      if ({8'h00, rd_data_b[15:8]} !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, rd_data_b[15:8], e.exp); end
    end
  endtask

  task automatic test_param();
    tick();
    w_wr_en = 1'b1; w_wr_addr = 5'd20; w_wr_data = 16'hBEEF;
    w_rd_addr = {5'd20, 5'd20, 5'd20};
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 3; k++) sb.push_back('{$sformatf("wide_p%0d_ph%0d", k, ph), 16'hBEEF});
      #1;
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front(); checks++;
        if (w_rd_data[k*16 +: 16] !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, w_rd_data[k*16 +: 16], e.exp); end
      end
      if (ph == 0) begin tick(); w_wr_en = 1'b0; end
    end
    w_rd_addr = {5'd11, 5'd10, 5'd20};
    sb.push_back('{"wide_zero", 16'h0000});
    sb.push_back('{"wide_one", 16'h0001});
    #1;
    e = sb.pop_front(); checks++;
    if (w_rd_data[31:16] !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, w_rd_data[31:16], e.exp); end
    e = sb.pop_front(); checks++;
    if (w_rd_data[47:32] !== e.exp) begin errors++; $display("FAIL %s got %h want %h", e.name, w_rd_data[47:32], e.exp); end
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    acc_we = 1'b0; acc_wdata = '0; flag_we = 1'b0; carry_out = 1'b0;
    w_rd_addr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    w_acc_we = 1'b0; w_acc_wdata = '0; w_flag_we = 1'b0; w_carry_out = 1'b0;
    #12 reset = 1'b0;
    tick();
    test_reset();
    test_constants();
    test_acc_contention();
    test_flag_merge();
    test_bypass();
    test_back_to_back();
    test_param();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_residue got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
